// File: rtl/quant_pkg.sv
// Shared constants for the quantizer gain table: default widths, register
// bit positions and readout latency.
package quant_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_GAIN_W = 16;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned WR_TGL_BIT = 31;
  localparam int unsigned CM_TGL_BIT = 30;
  localparam int unsigned RD_LATENCY = 2;

endpackage

// File: rtl/quant_gain_ram.sv
// Simple dual-port gain RAM: one write port, one registered read port whose
// output register is synchronously reset.
module quant_gain_ram #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/quant_gain_loader.sv
// Double-buffered per-channel gain table: software toggles write shadow-bank
// entries and request a bank swap that takes effect on the next frame sync.
module quant_gain_loader
  import quant_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned GAIN_W = DEF_GAIN_W
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [REG_W-1:0]  addr_reg,
  input  logic [REG_W-1:0]  data_reg,
  input  logic              sync_in,
  input  logic              valid_in,
  output logic [GAIN_W-1:0] gain_out,
  output logic              gain_valid,
  output logic              sync_out,
  output logic              active_bank,
  output logic              commit_pending,
  output logic [CNT_W-1:0]  wr_count
);

  logic [REG_W-1:0]  addr_q1, addr_q2;
  logic [GAIN_W-1:0] data_q1, data_q2;
  logic [1:0]        cap_fill;
  logic              armed, last_wr_tgl, last_cm_tgl;
  logic              stable_c, wr_evt_c, cm_evt_c, swap_c;
  logic              unused_data_c;

  logic [ADDR_W-1:0] chan_cnt, rd_idx_c;
  logic              rd_bank_c;
  logic [ADDR_W:0]   rd_addr_q;
  logic              rd_vld_q, sync_q;

  assign unused_data_c = ^data_reg[REG_W-1:GAIN_W];

  // Two-stage capture of the bus-side registers; no reset needed on the data path
  always_ff @(posedge user_clk) begin
    addr_q1 <= addr_reg;
    addr_q2 <= addr_q1;
    data_q1 <= data_reg[GAIN_W-1:0];
    data_q2 <= data_q1;
  end

  // cap_fill keeps pre-reset leftovers in the capture stages from looking stable
  always_ff @(posedge user_clk) begin
    if (user_rst) cap_fill <= '0;
    else          cap_fill <= {cap_fill[0], 1'b1};
  end

  assign stable_c = cap_fill[1] && (addr_q1 == addr_q2);
  assign wr_evt_c = armed && stable_c && (addr_q2[WR_TGL_BIT] != last_wr_tgl);
  assign cm_evt_c = armed && stable_c && (addr_q2[CM_TGL_BIT] != last_cm_tgl);
  assign swap_c   = sync_in && commit_pending;

  // Toggle tracking, commit/swap and write accounting
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      armed          <= 1'b0;
      last_wr_tgl    <= 1'b0;
      last_cm_tgl    <= 1'b0;
      commit_pending <= 1'b0;
      active_bank    <= 1'b0;
      wr_count       <= '0;
    end else begin
      if (stable_c && !armed) begin
        armed       <= 1'b1;
        last_wr_tgl <= addr_q2[WR_TGL_BIT];
        last_cm_tgl <= addr_q2[CM_TGL_BIT];
      end
      if (wr_evt_c) begin
        last_wr_tgl <= addr_q2[WR_TGL_BIT];
        wr_count    <= wr_count + CNT_W'(1);
      end
      if (cm_evt_c) last_cm_tgl <= addr_q2[CM_TGL_BIT];
      if (swap_c)   active_bank <= ~active_bank;
      commit_pending <= (commit_pending && !swap_c) || cm_evt_c;
    end
  end

  // A sync cycle reads channel 0 from the bank that is active after the swap
  assign rd_idx_c  = sync_in ? '0 : chan_cnt;
  assign rd_bank_c = swap_c ? ~active_bank : active_bank;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      chan_cnt   <= '0;
      rd_addr_q  <= '0;
      rd_vld_q   <= 1'b0;
      sync_q     <= 1'b0;
      gain_valid <= 1'b0;
      sync_out   <= 1'b0;
    end else begin
      chan_cnt   <= valid_in ? rd_idx_c + ADDR_W'(1) : rd_idx_c;
      rd_addr_q  <= {rd_bank_c, rd_idx_c};
      rd_vld_q   <= valid_in;
      sync_q     <= sync_in;
      gain_valid <= rd_vld_q;
      sync_out   <= sync_q;
    end
  end

  quant_gain_ram #(
    .ADDR_W (ADDR_W + 1),
    .DATA_W (GAIN_W)
  ) u_ram (
    .clk   (user_clk),
    .rst   (user_rst),
    .we    (wr_evt_c && !user_rst),
    .waddr ({~active_bank, addr_q2[ADDR_W-1:0]}),
    .wdata (data_q2),
    .re    (rd_vld_q),
    .raddr (rd_addr_q),
    .rdata (gain_out)
  );

endmodule
